fp_mac_sequencer: RTL

- Sequences one dot-product job through the pipelined FP16 multiply-accumulate datapath (11-bit significand stages).
- Accepts a job (base address, element count) and issues one operand-pair read per cycle to a 1-cycle synchronous operand memory.
- Drives aligned valid, first and last markers into the MAC pipeline, waits for the pipeline to drain, then presents the accumulated result through a valid/ready handshake.

---
 rtl/fp_mac_pkg.sv | 12 +
 rtl/fp_mac_drain_timer.sv | 35 +++
 rtl/fp_mac_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP16 multiply-accumulate sequencer and its datapath.
package fp_mac_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   // Must track the number of MAC datapath stages.
   localparam int PIPE_LAT_DEF = 4;

   localparam int FP16_SIG_W = 11;
   localparam int FP16_EXP_W = 5;

endpackage

// File: rtl/fp_mac_drain_timer.sv
// Loadable down-counter that pulses expired on the cycle its count reaches zero.
module fp_mac_drain_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             cancel,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;
   logic             running;

   assign expired = running && (cnt == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt     <= '0;
         running <= 1'b0;
      end else if (cancel) begin
         cnt     <= '0;
         running <= 1'b0;
      end else if (load) begin
         cnt     <= load_val;
         running <= 1'b1;
      end else if (expired) begin
         running <= 1'b0;
      end else if (running) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fp_mac_sequencer.sv
// Issues one dot-product job into the FP16 MAC pipeline and hands back the result.
module fp_mac_sequencer
   import fp_mac_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              abort,
   input  logic              hold,
   output logic              op_rd_en,
   output logic [ADDR_W-1:0] op_addr,
   output logic              mac_in_valid,
   output logic              mac_acc_clear,
   output logic              mac_in_last,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_empty,
   output logic [LEN_W-1:0]  res_count
);

   localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

   state_t           state, state_nx;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] index;
   logic             last_issue;
   logic             drain_load;
   logic             drain_exp;

   assign last_issue = (index == len_q - LEN_W'(1));
   assign busy       = (state != IDLE);
   assign res_valid  = (state == DONE);

   // Loading PIPE_LAT-1 when the last read issues puts res_valid PIPE_LAT+1 cycles after it.
   fp_mac_drain_timer #(.CNT_W(DRAIN_W)) u_drain (
      .clock    (clock),
      .reset    (reset),
      .load     (drain_load),
      .cancel   (abort),
      .load_val (DRAIN_W'(PIPE_LAT - 1)),
      .expired  (drain_exp)
   );

   always_comb begin
      state_nx   = state;
      op_rd_en   = 1'b0;
      drain_load = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = (length == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (!hold) begin
               op_rd_en = 1'b1;
               if (last_issue) begin
                  state_nx   = DRAIN;
                  drain_load = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (abort)          state_nx = IDLE;
            else if (drain_exp) state_nx = DONE;
         end
         DONE: begin
            if (res_ready || abort) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         len_q         <= '0;
         index         <= '0;
         op_addr       <= '0;
         mac_in_valid  <= 1'b0;
         mac_acc_clear <= 1'b0;
         mac_in_last   <= 1'b0;
         res_empty     <= 1'b0;
         res_count     <= '0;
      end else begin
         state         <= state_nx;
         mac_in_valid  <= op_rd_en;
         mac_acc_clear <= op_rd_en && (index == '0);
         mac_in_last   <= op_rd_en && last_issue;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q     <= length;
                  index     <= '0;
                  op_addr   <= base_addr;
                  res_empty <= (length == '0);
               end
            end
            ISSUE: begin
               if (op_rd_en) begin
                  index   <= index + LEN_W'(1);
                  op_addr <= op_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (state_nx == DONE) res_count <= len_q;
            end
            DONE: begin
               if (state_nx == IDLE) begin
                  res_empty <= 1'b0;
                  res_count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
